sync_ram_rd_streamer: RTL and testbench

SYNC_RAM_RD_STREAMER -- requirements
Module: sync_ram_rd_streamer

---
 rtl/sync_ram_rd_streamer.sv | 175 +++++++++++++++++
 tb/tb_sync_ram_rd_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_rd_streamer
//  Description : Reads a burst of consecutive words from a synchronous RAM
//                port and presents them as a valid/ready stream. A small
//                credit-controlled FIFO absorbs RAM latency and sink stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_rd_streamer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [ADDR_WIDTH-1:0] BaseAddr_DI,
  input  logic [ADDR_WIDTH-1:0] Len_DI,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  input  logic [DATA_WIDTH-1:0] RdData_DI,
  output logic                  Valid_SO,
  input  logic                  Ready_SI,
  output logic [DATA_WIDTH-1:0] Data_DO,
  output logic                  Last_SO
);

  // FIFO holds every read that can be outstanding: the RAM pipeline plus
  // two slots so that a full-rate stream never starves.
  localparam int FIFO_DEPTH = RAM_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;   // one extra bit: Len all-ones means 2^ADDR_WIDTH reads
  logic                  done_pulse;

  logic [RAM_LATENCY-1:0] pipe_valid;
  logic [RAM_LATENCY-1:0] pipe_last;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      inflight;

  logic issue;
  logic final_issue;
  logic push;
  logic pop;
  logic fifo_nonempty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Count reads travelling through the RAM latency pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_valid[i]);
    end
  end

  // A read may only be issued if its data is guaranteed a FIFO slot; the
  // pop happening in this same cycle is deliberately not credited.
  assign issue = (state == ISSUE) && (remaining != '0) &&
                 ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
  assign final_issue   = issue && (remaining == (ADDR_WIDTH + 1)'(1));
  assign push          = pipe_valid[RAM_LATENCY-1];
  assign fifo_nonempty = (fifo_count != '0);
  assign pop           = Valid_SO && Ready_SI;

  // Outputs are forced low while reset is held so nothing leaks mid-reset.
  assign Busy_SO  = !Rst_RI && (state != IDLE);
  assign Done_SO  = !Rst_RI && done_pulse;
  assign CSel_SO  = !Rst_RI && issue;
  assign WrEn_SO  = 1'b0;
  assign Addr_DO  = CSel_SO ? addr : '0;
  assign Valid_SO = !Rst_RI && fifo_nonempty;
  assign Data_DO  = Valid_SO ? fifo_data[rd_ptr] : '0;
  assign Last_SO  = Valid_SO && fifo_last[rd_ptr];

  // Burst control: accept a request, walk the addresses, wait for the last beat.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= pop && Last_SO;
      unique case (state)
        IDLE: begin
          if (Start_SI) begin
            addr      <= BaseAddr_DI;
            remaining <= {1'b0, Len_DI} + (ADDR_WIDTH + 1)'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            if (final_issue) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && Last_SO) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift a valid/last tag alongside each read so its data is captured on time.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= final_issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  // FIFO storage; contents are only observed through the occupancy count.
  always_ff @(posedge Clk_CI) begin
    if (push) begin
      fifo_data[wr_ptr] <= RdData_DI;
      fifo_last[wr_ptr] <= pipe_last[RAM_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy, allowing simultaneous push and pop.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_rd_streamer
//  Description : Bench for sync_ram_rd_streamer; two instances (RAM latency
//                1 and 2) against a burst-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram_rd_streamer;

  localparam int AW = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start  [2];
  logic [AW-1:0] base_a [2];
  logic [AW-1:0] len_a  [2];
  logic          ready  [2];
  logic          busy   [2];
  logic          done   [2];
  logic          cs     [2];
  logic          we     [2];
  logic          valid  [2];
  logic          last   [2];
  logic [AW-1:0] addr   [2];
  logic [DW-1:0] rdata  [2];
  logic [DW-1:0] dout   [2];
  logic [DW-1:0] rd1    [2];
  logic [DW-1:0] rd2    [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [AW-1:0] exp_addr  [2][$];
  beat_t         exp_beats [2][$];
  int            addr_log  [2][$];
  int            beat_log  [2][$];
  bit            m_busy    [2];
  bit            m_done    [2];
  int            m_out     [2];
  int            since     [2];
  bit            prev_stall[2];
  logic [DW-1:0] prev_data [2];
  logic          prev_last [2];
  int hs_count[2], first_hs_cyc[2], last_hs_cyc[2];
  int first_iss_cyc[2], last_iss_cyc[2], acc_cyc[2], done_cyc[2];
  int chain_accepts[2];

  logic [AW-1:0] a044 [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
  int            d044 [4] = '{102, 103, 104, 105};
  logic [AW-1:0] a045 [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
  int            d045 [4] = '{114, 115, 100, 101};

  always #5 clk = ~clk;

  sync_ram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1)) u_dut0 (
    .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start[0]), .BaseAddr_DI(base_a[0]),
    .Len_DI(len_a[0]), .Busy_SO(busy[0]), .Done_SO(done[0]), .CSel_SO(cs[0]),
    .WrEn_SO(we[0]), .Addr_DO(addr[0]), .RdData_DI(rdata[0]), .Valid_SO(valid[0]),
    .Ready_SI(ready[0]), .Data_DO(dout[0]), .Last_SO(last[0])
  );

  sync_ram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(2)) u_dut1 (
    .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start[1]), .BaseAddr_DI(base_a[1]),
    .Len_DI(len_a[1]), .Busy_SO(busy[1]), .Done_SO(done[1]), .CSel_SO(cs[1]),
    .WrEn_SO(we[1]), .Addr_DO(addr[1]), .RdData_DI(rdata[1]), .Valid_SO(valid[1]),
    .Ready_SI(ready[1]), .Data_DO(dout[1]), .Last_SO(last[1])
  );

  // RAM contents mem[i] = i + 100; idle cycles return junk.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rd1[k] <= cs[k] ? DW'(int'(addr[k]) + 100) : DW'($urandom);
      rd2[k] <= rd1[k];
    end
  end
  assign rdata[0] = rd1[0];
  assign rdata[1] = rd2[1];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare every cycle against the burst-level model and advance it.
  always @(negedge clk) begin : cmp
    int       lat;
    bit       hs;
    bit       lhs;
    bit       acc;
    beat_t    hb;
    logic [25:0] ov;
    logic [22:0] iv;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 2;
      if (rst) begin
        ov = {busy[k], done[k], cs[k], we[k], valid[k], last[k], addr[k], dout[k]};
        chk(ov == '0, "reset_outputs", longint'(ov), 0);
        exp_addr[k].delete();
        exp_beats[k].delete();
        m_busy[k] = 0; m_done[k] = 0; m_out[k] = 0; since[k] = 0; prev_stall[k] = 0;
      end else begin
        chk(we[k] == 1'b0, "wren_low", longint'(we[k]), 0);
        chk(busy[k] == m_busy[k], "busy", longint'(busy[k]), longint'(m_busy[k]));
        chk(done[k] == m_done[k], "done", longint'(done[k]), longint'(m_done[k]));
        if (!m_busy[k]) begin
          iv = {cs[k], valid[k], last[k], addr[k], dout[k]};
          chk(iv == '0, "idle_outputs", longint'(iv), 0);
        end
        if (since[k] == 1)
          chk(cs[k] == 1'b1, "first_issue_latency", longint'(cs[k]), 1);
        if (since[k] >= 1 && since[k] <= lat + 1)
          chk(valid[k] == 1'b0, "early_valid", longint'(valid[k]), 0);
        if (since[k] == lat + 2)
          chk(valid[k] == 1'b1, "first_valid_latency", longint'(valid[k]), 1);
        if (cs[k]) begin
          if (exp_addr[k].size() == 0) begin
            chk(1'b0, "unexpected_issue", longint'(addr[k]), -1);
          end else begin
            chk(addr[k] == exp_addr[k][0], "issue_addr", longint'(addr[k]), longint'(exp_addr[k][0]));
            void'(exp_addr[k].pop_front());
          end
          if (first_iss_cyc[k] < 0) first_iss_cyc[k] = cyc;
          last_iss_cyc[k] = cyc;
          addr_log[k].push_back(int'(addr[k]));
        end
        chk(m_out[k] + int'(cs[k]) <= lat + 2, "credit_limit", m_out[k] + int'(cs[k]), lat + 2);
        if (prev_stall[k])
          chk(valid[k] && dout[k] == prev_data[k] && last[k] == prev_last[k], "stall_hold",
              longint'({valid[k], last[k], dout[k]}), longint'({1'b1, prev_last[k], prev_data[k]}));
        hs  = valid[k] && ready[k];
        lhs = 0;
        if (hs) begin
          if (exp_beats[k].size() == 0) begin
            chk(1'b0, "spurious_beat", longint'(dout[k]), -1);
          end else begin
            hb = exp_beats[k].pop_front();
            chk(dout[k] == hb.d && last[k] == hb.l, "beat",
                longint'({dout[k], last[k]}), longint'({hb.d, hb.l}));
            lhs = hb.l;
          end
          beat_log[k].push_back(int'(dout[k]));
          hs_count[k]++;
          if (hs_count[k] == 1) first_hs_cyc[k] = cyc;
          last_hs_cyc[k] = cyc;
        end
        if (done[k]) done_cyc[k] = cyc;
        acc = !m_busy[k] && start[k];
        if (acc) begin
          if (done[k]) chain_accepts[k]++;
          for (int i = 0; i <= int'(len_a[k]); i++) begin
            exp_addr[k].push_back(AW'(int'(base_a[k]) + i));
            hb.d = DW'(((int'(base_a[k]) + i) % 16) + 100);
            hb.l = (i == int'(len_a[k]));
            exp_beats[k].push_back(hb);
          end
          addr_log[k].delete();
          beat_log[k].delete();
          hs_count[k] = 0; first_hs_cyc[k] = -1; first_iss_cyc[k] = -1; acc_cyc[k] = cyc;
        end
        m_out[k]  = m_out[k] + int'(cs[k]) - int'(hs);
        m_busy[k] = (m_busy[k] && !lhs) || acc;
        m_done[k] = lhs;
        if (acc) since[k] = 1;
        else if (since[k] >= 1 && since[k] < 1000) since[k] = since[k] + 1;
        prev_stall[k] = valid[k] && !ready[k];
        prev_data[k]  = dout[k];
        prev_last[k]  = last[k];
      end
    end
    cyc++;
  end

  function automatic logic pick_ready(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 3) == 0;
      2:       return $urandom_range(0, 3) != 0;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  // Called at posedge+1 with the instance idle; returns in its Done cycle.
  task automatic run_burst(input int k, input int b, input int l, input int mode);
    int n;
    start[k]  = 1'b1;
    base_a[k] = AW'(b);
    len_a[k]  = AW'(l);
    ready[k]  = pick_ready(mode, 0);
    n = 1;
    forever begin
      @(posedge clk); #1;
      start[k]  = m_busy[k] && ($urandom_range(0, 7) == 0);
      base_a[k] = AW'($urandom);
      len_a[k]  = AW'($urandom);
      ready[k]  = pick_ready(mode, n);
      n++;
      if (m_done[k]) break;
      if (n > 2000) begin
        chk(1'b0, "burst_timeout", n, 0);
        break;
      end
    end
    start[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        start[k]  = 1'b0;
        ready[k]  = $urandom_range(0, 1) == 1;
        base_a[k] = AW'($urandom);
        len_a[k]  = AW'($urandom);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual %0d required %0d", cyc, 0);
    $fatal(1, "global timeout");
  end

  // Directed scenarios followed by randomized bursts.
  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; base_a[k] = '0; len_a[k] = '0; ready[k] = 1'b0;
      m_busy[k] = 0; m_done[k] = 0; m_out[k] = 0; since[k] = 0; prev_stall[k] = 0;
      hs_count[k] = 0; first_hs_cyc[k] = -1; last_hs_cyc[k] = -1;
      first_iss_cyc[k] = -1; last_iss_cyc[k] = -1; acc_cyc[k] = -1; done_cyc[k] = -1;
      chain_accepts[k] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // base 2, len 3, latency 1
    run_burst(0, 2, 3, 0);
    idle(1);
    chk(addr_log[0].size() == 4, "l044_issue_count", addr_log[0].size(), 4);
    chk(beat_log[0].size() == 4, "l044_beat_count", beat_log[0].size(), 4);
    for (int i = 0; i < 4 && i < addr_log[0].size() && i < beat_log[0].size(); i++) begin
      chk(addr_log[0][i] == int'(a044[i]), "l044_addr", addr_log[0][i], int'(a044[i]));
      chk(beat_log[0][i] == d044[i], "l044_data", beat_log[0][i], d044[i]);
    end
    chk(last_iss_cyc[0] - first_iss_cyc[0] == 3, "l044_consecutive_issue",
        last_iss_cyc[0] - first_iss_cyc[0], 3);
    chk(first_iss_cyc[0] == acc_cyc[0] + 1, "l044_issue_latency", first_iss_cyc[0], acc_cyc[0] + 1);
    chk(first_hs_cyc[0] == acc_cyc[0] + 3, "l044_valid_latency", first_hs_cyc[0], acc_cyc[0] + 3);
    chk(done_cyc[0] == last_hs_cyc[0] + 1, "l044_done_timing", done_cyc[0], last_hs_cyc[0] + 1);

    // address wrap: base 14, len 3
    run_burst(0, 14, 3, 0);
    idle(1);
    chk(beat_log[0].size() == 4, "l045_beat_count", beat_log[0].size(), 4);
    for (int i = 0; i < 4 && i < addr_log[0].size() && i < beat_log[0].size(); i++) begin
      chk(addr_log[0][i] == int'(a045[i]), "l045_addr", addr_log[0][i], int'(a045[i]));
      chk(beat_log[0][i] == d045[i], "l045_data", beat_log[0][i], d045[i]);
    end

    // full address space, one beat per cycle
    run_burst(0, 9, 15, 0);
    idle(1);
    chk(hs_count[0] == 16, "l049_beat_count", hs_count[0], 16);
    chk(last_hs_cyc[0] - first_hs_cyc[0] == 15, "l049_throughput", last_hs_cyc[0] - first_hs_cyc[0], 15);
    if (addr_log[0].size() == 16)
      chk(addr_log[0][7] == 0 && addr_log[0][15] == 8, "l049_wrap",
          addr_log[0][7] * 100 + addr_log[0][15], 8);
    else
      chk(1'b0, "l049_issue_count", addr_log[0].size(), 16);

    // latency 2, len 7, ready 1,0,0,...
    run_burst(1, 3, 7, 1);
    idle(1);
    chk(hs_count[1] == 8, "l046_beat_count", hs_count[1], 8);
    if (beat_log[1].size() == 8)
      chk(beat_log[1][7] == 110, "l046_last_data", beat_log[1][7], 110);

    // start ignored while busy, then accepted in the Done cycle
    chain_accepts[0] = 0;
    run_burst(0, 6, 7, 3);
    run_burst(0, 4, 1, 0);
    idle(1);
    chk(chain_accepts[0] == 1, "l047_done_cycle_accept", chain_accepts[0], 1);
    chk(first_iss_cyc[0] == acc_cyc[0] + 1, "l047_chain_issue", first_iss_cyc[0], acc_cyc[0] + 1);

    // reset after the 2nd of 8 beats
    start[0] = 1'b1; base_a[0] = 4'd5; len_a[0] = 4'd7; ready[0] = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      n++;
      if (hs_count[0] >= 2) break;
      if (n > 200) begin
        chk(1'b0, "l048_timeout", n, 0);
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    chk(hs_count[0] == 2, "l048_no_late_beats", hs_count[0], 2);
    run_burst(0, 0, 7, 0);
    idle(1);
    chk(hs_count[0] == 8, "l048_next_burst", hs_count[0], 8);

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      int k;
      int l;
      k = $urandom_range(0, 1);
      l = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 15);
      run_burst(k, $urandom_range(0, 15), l, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
